// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU that consumes the 4-bit control code from the ALU control
// decoder. An operation (code + two operands) is taken over an in_valid /
// in_ready handshake. The registered result, a zero flag and an illegal-code
// flag go back over an out_valid / out_ready handshake.
//
// Single-cycle operations produce their result one cycle after accept. They
// sustain one result per cycle when out_ready stays high. Multiply is an
// iterative shift-add over WIDTH cycles.
//
// Configuration macro:
//   ALU_EXEC_MUL_EN - when defined, code 1000 is an iterative multiply with
//                     its BUSY state, counter and shift registers. When
//                     undefined, none of that hardware is built and code
//                     1000 is reported as illegal with a 1-cycle latency.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 4)
//   CNT_W  multiply iteration counter width (2**CNT_W > WIDTH)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation request valid
//   in_ready   unit can accept a request this cycle
//   alu_ctrl   4-bit ALU control code
//   src_a      operand A
//   src_b      operand B
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   result     registered result
//   zero       result == 0
//   illegal    accepted code was unsupported
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // Reject parameter combinations that would break the multiply counter or
    // the slt zero-extension at elaboration time, rather than in silicon.
    if (WIDTH < 4 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
        $error("alu_exec_unit: WIDTH must be >= 4 and 2**CNT_W must exceed WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DONE = 2'b01
`ifdef ALU_EXEC_MUL_EN
        ,
        BUSY = 2'b10
`endif
    } state_t;

    state_t state;

    logic             accept;
    logic             slt_lt;
    logic [WIDTH-1:0] op_result;
    logic             op_illegal;

`ifdef ALU_EXEC_MUL_EN
    logic             op_mul;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_sum;
`endif

    // A finished result that is being consumed this cycle frees the unit, so
    // a new request can be taken in the same cycle (back-to-back issue).
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    assign slt_lt = $signed(src_a) < $signed(src_b);

    // Decode the control code into a single-cycle result. Anything that is
    // not a supported code produces a zero result with the illegal flag set.
    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        op_mul     = 1'b0;
`endif
        case (alu_ctrl)
            4'b0010: op_result = src_a + src_b;
            4'b0110: op_result = src_a - src_b;
            4'b0000: op_result = src_a & src_b;
            4'b0001: op_result = src_a | src_b;
            4'b0111: op_result = {{(WIDTH-1){1'b0}}, slt_lt};
            4'b1100: op_result = ~(src_a | src_b);
`ifdef ALU_EXEC_MUL_EN
            4'b1000: op_mul    = 1'b1;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    // One shift-add step: fold the multiplicand in when the current
    // multiplier bit is set. Used both for the accumulator update and for
    // the final result on the last iteration.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;
`endif

    // Control FSM and all output/datapath registers. IDLE and DONE share the
    // launch path because a DONE result being drained can be replaced by a
    // new operation in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ALU_EXEC_MUL_EN
                        if (op_mul) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            acc       <= '0;
                            mcand     <= src_a;
                            mplier    <= src_b;
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= op_result;
                            zero      <= (op_result == '0);
                            illegal   <= op_illegal;
                        end
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= acc_sum;
                        zero      <= (acc_sum == '0);
                        illegal   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 4-bit ALU control code produced by the ALU control decoder.
- Accepts an operation with two operands over a valid/ready handshake and computes the result.
- Returns the registered result, a zero flag and an illegal-code flag over a second valid/ready handshake.
- Single-cycle ops complete in 1 cycle; multiply runs iteratively (shift-add) over WIDTH cycles. Sits between the register-read stage and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, 6, width of the multiply iteration counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request this cycle.
- alu_ctrl  input  4  ALU control code.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- illegal  output  1  accepted code was unsupported.

Behaviour:
- Reset: rst_n sampled low at a clock edge puts the FSM in IDLE. Reset values: out_valid=0, result=0, zero=0, illegal=0, counter=0, internal operand/accumulator registers=0. Any in-flight operation is discarded, including one mid-multiply.
- States: IDLE, BUSY (multiply iterating), DONE (result held).
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 throughout BUSY.
- Accept occurs when in_valid && in_ready. src_a, src_b and alu_ctrl are sampled only at accept.
- Codes:
  - 0010 add: a+b modulo 2^WIDTH.
  - 0110 sub: a-b modulo 2^WIDTH.
  - 0000 and.
  - 0001 or.
  - 0111 slt: signed compare, result 1 if a<b else 0, zero-extended.
  - 1100 nor.
  - 1000 mul: low WIDTH bits of the unsigned product (see Optional Feature).
  - Any other code: result 0, illegal=1.
- Single-cycle codes and illegal codes: next state DONE with result, zero and illegal registered. Latency 1 cycle from accept to out_valid.
- mul: next state BUSY; counter loads 0; accumulator clears.
  - Each BUSY cycle: if multiplier LSB is 1, add multiplicand to the accumulator; multiplicand shifts left 1; multiplier shifts right 1; counter increments.
  - When counter reaches WIDTH-1 in BUSY, that cycle's iteration completes and the next state is DONE with result = accumulator.
  - Latency WIDTH+1 cycles from accept to out_valid.
- DONE: out_valid=1. result, zero and illegal are stable until the cycle where out_ready=1.
  - On out_ready without a new accept: go to IDLE, out_valid=0 next cycle. result holds its last value.
  - On out_ready with a simultaneous accept: the new operation is launched immediately (back-to-back). Single-cycle ops sustain 1 result per cycle.
- illegal and zero are updated only when a new result is registered.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined: code 1000 is a multiply exactly as in Behaviour; BUSY state, counter and shift registers are present.
- Undefined: BUSY state and multiply hardware are not built. Code 1000 is treated as illegal: result 0, illegal=1, latency 1.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release → out_valid=0, result=0, in_ready=1.
- add a=0xFFFFFFFF, b=1 → 1 cycle later out_valid=1, result=0, zero=1, illegal=0. sub a=5, b=7 → result=0xFFFFFFFE.
- slt a=0xFFFFFFFF (-1), b=1 → result=1. slt a=1, b=0xFFFFFFFF → result=0, zero=1.
- Back-to-back: in_valid held high with out_ready=1 for and/or/nor sequence 0xF0F0/0x0FF0 → results 0x00F0, 0xFFF0, 0xFFFF000F on consecutive cycles. out_ready=0 for 3 cycles → result stable, in_ready=0.
- mul a=12345, b=678 (ALU_EXEC_MUL_EN defined) → in_ready=0 for 32 cycles, out_valid at cycle 33, result=8369910. Same stimulus with the macro undefined → result=0, illegal=1 after 1 cycle.
- Assert rst_n=0 at BUSY cycle 10 of a multiply → next cycle IDLE, out_valid=0, result=0. A new add 2+3 then yields 5 with no residue from the aborted multiply.
